// File: rtl/mux16_rr_scheduler.sv
// ----------------------------------------------------------------------------
// mux16_rr_scheduler
//   Round-robin owner of one shared 16:1 bit-select mux. One requester at a
//   time gets the mux select; the selected bit comes back registered and
//   tagged with its owner. A tenure lasts while the owner holds req, capped at
//   MAX_HOLD cycles, and every tenure is followed by a one-cycle GAP before
//   the next arbitration in IDLE.
//
//   Ports
//     clk         rising-edge clock
//     reset_n     asynchronous active-low reset
//     req[15:0]   level requests, one per requester
//     mux_bit     output of the shared MUX16_1 (combinational from sel)
//     sel[3:0]    mux select = current / last owner index
//     gnt[15:0]   one-hot grant, zero outside GRANT
//     busy        high in GRANT or GAP
//     data_out    registered mux_bit captured during GRANT
//     data_valid  high the cycle after each GRANT cycle
//     data_owner  owner index that produced data_out
// ----------------------------------------------------------------------------

// Per-lane rotation: lane i looks at physical requester (base + i) mod 16,
// so lane 0 is always the highest-priority candidate for this arbitration.
module mux16_rr_lane #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4,
    parameter int LANE    = 0
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   base,
    output logic               rot_req,
    output logic [IDX_W-1:0]   phys_idx
);
    // Index arithmetic wraps naturally in IDX_W bits.
    assign phys_idx = base + IDX_W'(LANE);
    assign rot_req  = req[phys_idx];
endmodule

module mux16_rr_scheduler #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req,
    input  logic        mux_bit,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        busy,
    output logic        data_out,
    output logic        data_valid,
    output logic [3:0]  data_owner
);
    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
    // Value of hold_cnt on the final cycle of a capped tenure.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Registered response towards the requesters.
    typedef struct packed {
        logic             valid;
        logic             data;
        logic [IDX_W-1:0] owner;
    } rsp_t;

    state_e               state_q,    state_d;
    logic [IDX_W-1:0]     sel_q,      sel_d;
    logic [NUM_REQ-1:0]   gnt_q,      gnt_d;
    logic                 busy_q,     busy_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]     rr_ptr_q,   rr_ptr_d;
    rsp_t                 rsp_q,      rsp_d;

    // ------------------------------------------------------------------------
    // Arbitration: rotate the request vector so the search starts just after
    // the last winner, then pick the lowest set lane.
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0]                rot_base;
    logic [NUM_REQ-1:0]              rot_req;
    logic [NUM_REQ-1:0][IDX_W-1:0]   lane_idx;
    logic                            win_found;
    logic [IDX_W-1:0]                win_idx;

    assign rot_base = rr_ptr_q + 1'b1;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        mux16_rr_lane #(
            .NUM_REQ (NUM_REQ),
            .IDX_W   (IDX_W),
            .LANE    (g)
        ) u_lane (
            .req      (req),
            .base     (rot_base),
            .rot_req  (rot_req[g]),
            .phys_idx (lane_idx[g])
        );
    end

    // Scan from the lowest-priority lane upward so the last hit, i.e. the
    // lowest lane number, is the one that sticks.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_found = 1'b1;
                win_idx   = lane_idx[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered outputs.
    // ------------------------------------------------------------------------
    logic release_now;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = '0;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_d      = rsp_q;
        rsp_d.valid = 1'b0;
        release_now = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_GRANT;
                    sel_d      = win_idx;
                    gnt_d      = NUM_REQ'(1) << win_idx;
                    hold_cnt_d = '0;
                    rr_ptr_d   = win_idx;
                end
            end

            ST_GRANT: begin
                // Every GRANT cycle yields data, including the last one.
                rsp_d.valid = 1'b1;
                rsp_d.data  = mux_bit;
                rsp_d.owner = sel_q;

                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end

                // Owner drop and tenure cap fold into one exit; other
                // requesters never preempt.
                release_now = !req[sel_q] ||
                              ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST));

                if (release_now) begin
                    state_d = ST_GAP;
                end else begin
                    gnt_d = gnt_q;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_GRANT) || (state_d == ST_GAP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
            rsp_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_q      <= rsp_d;
        end
    end

    assign sel        = sel_q;
    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign data_out   = rsp_q.data;
    assign data_valid = rsp_q.valid;
    assign data_owner = rsp_q.owner;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_mux16_rr_scheduler
//   Directed bench. Stimulus pushes the expected (owner, bit) response of
//   every GRANT cycle into a queue; monitors pop and compare whenever
//   data_valid is seen. Grant/select/busy timing is checked inline.
//   u_dut runs with MAX_HOLD=8, u_dut0 with MAX_HOLD=0 (unlimited tenure).
// ----------------------------------------------------------------------------
module tb_mux16_rr_scheduler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] req, req0;
    logic [15:0] mux_pat;

    logic        mux_bit, mux_bit0;
    logic [3:0]  sel, sel0;
    logic [15:0] gnt, gnt0;
    logic        busy, busy0;
    logic        data_out, data_out0;
    logic        data_valid, data_valid0;
    logic [3:0]  data_owner, data_owner0;

    typedef struct packed {
        logic [3:0] owner;
        logic       data;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Model of the shared MUX16_1.
    assign mux_bit  = mux_pat[sel];
    assign mux_bit0 = mux_pat[sel0];

    mux16_rr_scheduler #(.MAX_HOLD(8), .HOLD_W(4)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .mux_bit    (mux_bit),
        .sel        (sel),
        .gnt        (gnt),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_owner (data_owner)
    );

    mux16_rr_scheduler #(.MAX_HOLD(0), .HOLD_W(4)) u_dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req0),
        .mux_bit    (mux_bit0),
        .sel        (sel0),
        .gnt        (gnt0),
        .busy       (busy0),
        .data_out   (data_out0),
        .data_valid (data_valid0),
        .data_owner (data_owner0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int o);
        exp_t e;
        e.owner = 4'(o);
        e.data  = mux_pat[o];
        q.push_back(e);
    endtask

    task automatic push_exp0(input int o);
        exp_t e;
        e.owner = 4'(o);
        e.data  = mux_pat[o];
        q0.push_back(e);
    endtask

    // Scoreboard monitors.
    always @(negedge clk) begin
        exp_t e;
        if (data_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dv_unexpected: got owner %0h data %0b expected no data_valid (t=%0t)",
                         data_owner, data_out, $time);
            end else begin
                e = q.pop_front();
                chk("dv_owner", 32'(data_owner), 32'(e.owner));
                chk("dv_data",  32'(data_out),   32'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (data_valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dv0_unexpected: got owner %0h data %0b expected no data_valid (t=%0t)",
                         data_owner0, data_out0, $time);
            end else begin
                e = q0.pop_front();
                chk("dv0_owner", 32'(data_owner0), 32'(e.owner));
                chk("dv0_data",  32'(data_out0),   32'(e.data));
            end
        end
    end

    // Called at posedge+1 of the first expected GRANT cycle of owner o.
    // req_after is applied during the last GRANT cycle and stays for GAP/IDLE.
    // Returns at posedge+1 of the cycle after the IDLE cycle.
    task automatic tenure(input int o, input int n, input logic [15:0] req_after);
        logic [15:0] oh;
        oh = 16'h0001 << o;
        for (int i = 1; i <= n; i++) begin
            if (i == n) req = req_after;
            push_exp(o);
            @(negedge clk);
            chk("gnt",  32'(gnt),  32'(oh));
            chk("sel",  32'(sel),  32'(o));
            chk("busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("gap_gnt",  32'(gnt),  32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_sel",  32'(sel),  32'(o));
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_gnt",  32'(gnt),  32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_dv",   32'(data_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req     = '0;
        req0    = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = '0;
        req0    = '0;
        mux_pat = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",   32'(gnt),        32'd0);
        chk("rst_sel",   32'(sel),        32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_dout",  32'(data_out),   32'd0);
        chk("rst_dv",    32'(data_valid), 32'd0);
        chk("rst_owner", 32'(data_owner), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // 1: single request from 0, one-cycle latency.
        mux_pat = 16'h0001;
        req     = 16'h0001;
        @(posedge clk); #1;
        tenure(0, 1, 16'h0000);

        // 2: all requesting, 8-cycle tenures, rotation 0..15 then 0.
        do_reset();
        mux_pat = 16'hA5C3;
        req     = 16'hFFFF;
        @(posedge clk); #1;
        for (int o = 0; o < 16; o++) tenure(o, 8, 16'hFFFF);
        tenure(0, 8, 16'h0000);

        // 3: rr_ptr=5, requests 0 and 5 -> wrap to 0, then 5.
        do_reset();
        mux_pat = 16'h3C96;
        req     = 16'h0020;
        @(posedge clk); #1;
        tenure(5, 1, 16'h0000);
        req = 16'h0021;
        @(posedge clk); #1;
        tenure(0, 1, 16'h0020);
        tenure(5, 1, 16'h0000);

        // 4: owner 3 drops after 2 cycles, 9 pending.
        do_reset();
        mux_pat = 16'h5AA5;
        req     = 16'h0208;
        @(posedge clk); #1;
        tenure(3, 2, 16'h0200);
        tenure(9, 1, 16'h0000);

        // 5: reset mid-tenure of owner 7.
        do_reset();
        mux_pat = 16'h0080;
        req     = 16'h0080;
        @(posedge clk); #1;
        push_exp(7);
        @(negedge clk);
        chk("t5_gnt1", 32'(gnt), 32'h0080);
        @(posedge clk); #1;
        push_exp(7);
        @(negedge clk);
        chk("t5_gnt2", 32'(gnt), 32'h0080);
        @(posedge clk); #6;
        reset_n = 1'b0;
        #1;
        chk("t5_async_gnt",  32'(gnt),        32'd0);
        chk("t5_async_busy", 32'(busy),       32'd0);
        chk("t5_async_dv",   32'(data_valid), 32'd0);
        chk("t5_async_sel",  32'(sel),        32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        tenure(7, 1, 16'h0000);

        // 6: unlimited tenure, owner 2 held for 100 cycles.
        do_reset();
        mux_pat = 16'h0004;
        req0    = 16'h0004;
        @(posedge clk); #1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 100) req0 = 16'h0000;
            push_exp0(2);
            @(negedge clk);
            chk("t6_gnt", 32'(gnt0), 32'h0004);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t6_gap_gnt",  32'(gnt0),  32'd0);
        chk("t6_gap_busy", 32'(busy0), 32'd1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("q_empty",  32'(q.size()),  32'd0);
        chk("q0_empty", 32'(q0.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
